// File: rtl/lab1_entry_ctrl.sv
// Pushbutton entry front-end for the two-operand HEX datapath: debounces the key,
// steps LOAD_A -> LOAD_B -> SHOW, and adds blink feedback to the returned HEX patterns.
module lab1_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       key_n,
    input  logic [4:0] sw_in,
    input  logic [6:0] hex_in0,
    input  logic [6:0] hex_in1,
    input  logic [6:0] hex_in2,
    input  logic [6:0] hex_in3,
    input  logic [6:0] hex_in4,
    input  logic [6:0] hex_in5,
    output logic [9:0] sw_out,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [1:0] state
);

    localparam logic [1:0] ST_LOAD_A = 2'd0;
    localparam logic [1:0] ST_LOAD_B = 2'd1;
    localparam logic [1:0] ST_SHOW   = 2'd2;

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic             key_meta;
    logic             key_sync;
    logic             key_stable;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    logic [1:0]       state_d;
    logic [4:0]       op_a;
    logic [4:0]       op_b;

    logic [BLK_W-1:0] blink_cnt;
    logic             phase;

    logic             bad;
    logic [5:0]       blank;

    // Two-flop synchronizer; idle level of the active-low key is 1.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_stable <= 1'b1;
            deb_cnt    <= '0;
        end else if (key_sync == key_stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            key_stable <= key_sync;
            deb_cnt    <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Press fires in the cycle the stable level is about to fall, so the FSM
    // acts on the same edge that commits the new stable value.
    assign press = key_stable && !key_sync && (deb_cnt == DEB_LAST);

    always_comb begin
        state_d = state;
        if (press) begin
            case (state)
                ST_LOAD_A: state_d = ST_LOAD_B;
                ST_LOAD_B: state_d = ST_SHOW;
                ST_SHOW:   state_d = ST_LOAD_A;
                default:   state_d = ST_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOAD_A;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            state <= state_d;
            if (press) begin
                case (state)
                    ST_LOAD_A: op_a <= sw_in;
                    ST_LOAD_B: op_b <= sw_in;
                    default: begin
                        op_a <= '0;
                        op_b <= '0;
                    end
                endcase
            end
        end
    end

    assign sw_out = {op_a, op_b};

    // Every transition restarts the blink so the new state begins visible.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (press) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign bad = (hex_in5 == 7'b0000011) && (hex_in4 == 7'b0001000) &&
                 (hex_in3 == 7'b0100001);

    always_comb begin
        blank = '0;
        case (state)
            ST_LOAD_A: blank[1] = ~phase;
            ST_LOAD_B: blank[0] = ~phase;
            ST_SHOW:   blank    = {6{bad & ~phase}};
            default:   blank    = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            HEX0 <= SEG_OFF;
            HEX1 <= SEG_OFF;
            HEX2 <= SEG_OFF;
            HEX3 <= SEG_OFF;
            HEX4 <= SEG_OFF;
            HEX5 <= SEG_OFF;
        end else begin
            HEX0 <= blank[0] ? SEG_OFF : hex_in0;
            HEX1 <= blank[1] ? SEG_OFF : hex_in1;
            HEX2 <= blank[2] ? SEG_OFF : hex_in2;
            HEX3 <= blank[3] ? SEG_OFF : hex_in3;
            HEX4 <= blank[4] ? SEG_OFF : hex_in4;
            HEX5 <= blank[5] ? SEG_OFF : hex_in5;
        end
    end

endmodule

// File: tb/tb_lab1_entry_ctrl.sv
// Directed bench for lab1_entry_ctrl with short debounce and blink periods.
module tb_lab1_entry_ctrl;

    localparam int DEB = 4;
    localparam int BH  = 8;
    localparam logic [41:0] ALL_OFF = {6{7'h7F}};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        key_n;
    logic [4:0]  sw_in;
    logic [41:0] hin_all;
    logic [9:0]  sw_out;
    logic [1:0]  state;
    logic [6:0]  ho0, ho1, ho2, ho3, ho4, ho5;
    logic [41:0] hout_all;

    int checks = 0;
    int fails  = 0;

    assign hout_all = {ho5, ho4, ho3, ho2, ho1, ho0};

    lab1_entry_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_HALF(BH)) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .key_n   (key_n),
        .sw_in   (sw_in),
        .hex_in0 (hin_all[6:0]),
        .hex_in1 (hin_all[13:7]),
        .hex_in2 (hin_all[20:14]),
        .hex_in3 (hin_all[27:21]),
        .hex_in4 (hin_all[34:28]),
        .hex_in5 (hin_all[41:35]),
        .sw_out  (sw_out),
        .HEX0    (ho0),
        .HEX1    (ho1),
        .HEX2    (ho2),
        .HEX3    (ho3),
        .HEX4    (ho4),
        .HEX5    (ho5),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives the key low and returns at the negedge right after the state changes.
    task automatic press_wait(output int lat);
        logic [1:0] s0;
        s0    = state;
        key_n = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (state !== s0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_n   = 1'b1;
        sw_in   = '0;
        hin_all = ALL_OFF;
        @(negedge clk);
        @(negedge clk);
        checks++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (sw_out !== 10'h000) begin fails++; $display("FAIL reset_sw_out: got %h want 000", sw_out); end
        checks++; if (hout_all !== ALL_OFF) begin fails++; $display("FAIL reset_hex: got %h want %h", hout_all, ALL_OFF); end
        reset_n = 1'b1;
        repeat (3) tick();
        checks++; if (state !== 2'd0) begin fails++; $display("FAIL post_reset_state: got %0d want 0", state); end
        checks++; if (sw_out !== 10'h000) begin fails++; $display("FAIL post_reset_sw_out: got %h want 000", sw_out); end
        checks++; if (hout_all !== ALL_OFF) begin fails++; $display("FAIL post_reset_hex: got %h want %h", hout_all, ALL_OFF); end
    endtask

    task automatic test_load_a_press();
        int lat;
        sw_in = 5'b00111;
        press_wait(lat);
        checks++; if (lat != 2 + DEB) begin fails++; $display("FAIL press_a_latency: got %0d want %0d", lat, 2 + DEB); end
        checks++; if (state !== 2'd1) begin fails++; $display("FAIL press_a_state: got %0d want 1", state); end
        checks++; if (sw_out !== 10'b00111_00000) begin fails++; $display("FAIL press_a_sw_out: got %b want 0011100000", sw_out); end
        repeat (4) tick();
        checks++; if (state !== 2'd1) begin fails++; $display("FAIL hold_single_press: got %0d want 1", state); end
        key_n = 1'b1;
        repeat (8) tick();
        checks++; if (state !== 2'd1) begin fails++; $display("FAIL release_no_event: got %0d want 1", state); end
        checks++; if (sw_out !== 10'b00111_00000) begin fails++; $display("FAIL release_sw_out: got %b want 0011100000", sw_out); end
    endtask

    task automatic test_load_b_press();
        int lat;
        sw_in = 5'b00011;
        press_wait(lat);
        checks++; if (lat != 2 + DEB) begin fails++; $display("FAIL press_b_latency: got %0d want %0d", lat, 2 + DEB); end
        checks++; if (state !== 2'd2) begin fails++; $display("FAIL press_b_state: got %0d want 2", state); end
        checks++; if (sw_out !== 10'b00111_00011) begin fails++; $display("FAIL press_b_sw_out: got %b want 0011100011", sw_out); end
    endtask

    // Starts at the first negedge after entering SHOW.
    task automatic test_bad_blink();
        logic [41:0] exp;
        hin_all = {7'b0000011, 7'b0001000, 7'b0100001, 7'h12, 7'h24, 7'h40};
        for (int k = 1; k <= 17; k++) begin
            if (k == 4) key_n = 1'b1;
            tick();
            exp = (k >= 9 && k <= 16) ? ALL_OFF : hin_all;
            checks++; if (hout_all !== exp) begin fails++; $display("FAIL bad_blink_k%0d: got %h want %h", k, hout_all, exp); end
        end
        hin_all[27:21] = 7'b0101011;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++; if (hout_all !== hin_all) begin fails++; $display("FAIL banana_k%0d: got %h want %h", k, hout_all, hin_all); end
        end
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 5; g++) begin
            key_n = 1'b0;
            repeat (3) tick();
            key_n = 1'b1;
            repeat (5) tick();
            checks++; if (state !== 2'd2) begin fails++; $display("FAIL glitch%0d_state: got %0d want 2", g, state); end
        end
        checks++; if (sw_out !== 10'b00111_00011) begin fails++; $display("FAIL glitch_sw_out: got %b want 0011100011", sw_out); end
    endtask

    task automatic test_show_clear();
        int lat;
        hin_all = {7'h01, 7'h02, 7'h04, 7'h08, 7'b1111000, 7'h10};
        press_wait(lat);
        checks++; if (lat != 2 + DEB) begin fails++; $display("FAIL press_show_latency: got %0d want %0d", lat, 2 + DEB); end
        checks++; if (state !== 2'd0) begin fails++; $display("FAIL show_clear_state: got %0d want 0", state); end
        checks++; if (sw_out !== 10'h000) begin fails++; $display("FAIL show_clear_sw_out: got %h want 000", sw_out); end
    endtask

    // Starts at the first negedge after entering LOAD_A.
    task automatic test_load_a_blink();
        logic [41:0] exp;
        for (int k = 1; k <= 17; k++) begin
            if (k == 4) key_n = 1'b1;
            hin_all[6:0] = 7'(k * 3 + 1);
            tick();
            exp = hin_all;
            if (k >= 9 && k <= 16) exp[13:7] = 7'h7F;
            checks++; if (hout_all !== exp) begin fails++; $display("FAIL load_a_blink_k%0d: got %h want %h", k, hout_all, exp); end
        end
        checks++; if (state !== 2'd0) begin fails++; $display("FAIL load_a_hold_state: got %0d want 0", state); end
    endtask

    task automatic test_async_reset();
        int lat;
        sw_in = 5'b10101;
        repeat (2) tick();
        press_wait(lat);
        checks++; if (lat != 2 + DEB) begin fails++; $display("FAIL press_a2_latency: got %0d want %0d", lat, 2 + DEB); end
        checks++; if (sw_out !== 10'b10101_00000) begin fails++; $display("FAIL press_a2_sw_out: got %b want 1010100000", sw_out); end
        key_n = 1'b1;
        repeat (6) tick();
        hin_all = '0;
        repeat (2) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin fails++; $display("FAIL async_reset_state: got %0d want 0", state); end
        checks++; if (sw_out !== 10'h000) begin fails++; $display("FAIL async_reset_sw_out: got %h want 000", sw_out); end
        checks++; if (hout_all !== ALL_OFF) begin fails++; $display("FAIL async_reset_hex: got %h want %h", hout_all, ALL_OFF); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) tick();
        checks++; if (state !== 2'd0) begin fails++; $display("FAIL after_reset_state: got %0d want 0", state); end
        checks++; if (hout_all !== hin_all) begin fails++; $display("FAIL after_reset_hex: got %h want %h", hout_all, hin_all); end
    endtask

    initial begin
        test_reset();
        test_load_a_press();
        test_load_b_press();
        test_bad_blink();
        test_glitch();
        test_show_clear();
        test_load_a_blink();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
